// File: rtl/wl_seq_decoder_if.sv
// Bus between the RAM access controller (master) and the wordline sequencer (slave):
// request handshake plus the array control pins the sequencer drives.
interface wl_seq_decoder_if #(
    parameter int ROWS   = 8,
    parameter int ADDR_W = $clog2(ROWS)
);
    logic              en;
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic              ready;
    logic              busy;
    logic              precharge;
    logic [ROWS-1:0]   wl;
    logic              wr_en;
    logic              sense_en;
    logic              done;
    logic              error;

    modport master (
        output en, req, we, addr,
        input  ready, busy, precharge, wl, wr_en, sense_en, done, error
    );

    modport slave (
        input  en, req, we, addr,
        output ready, busy, precharge, wl, wr_en, sense_en, done, error
    );
endinterface

// File: rtl/wl_seq_decoder.sv
// Sequenced row decoder: precharge, then a one-hot wordline, then a sense strobe (read)
// or write enable (write). Every array pin is a flop, so the pins cannot glitch.
module wl_seq_decoder #(
    parameter int ROWS       = 8,
    parameter int ADDR_W     = $clog2(ROWS),
    parameter int PRE_CYCLES = 1,
    parameter int WL_CYCLES  = 2
) (
    input  logic            clk,
    input  logic            rst,
    wl_seq_decoder_if.slave bus
);
    localparam int MAX_CYCLES = (PRE_CYCLES > WL_CYCLES) ? PRE_CYCLES : WL_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    // The counter holds the cycles remaining after the current one, so zero means exit now.
    localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(PRE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WL_LOAD  = CNT_W'(WL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [31:0]      ROWS_U   = 32'(ROWS);
    localparam logic [ROWS-1:0]  WL_ONE   = {{(ROWS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        ACT,
        SENSE,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic              we_q, we_d;
    logic              err_q, err_d;

    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              precharge_q, precharge_d;
    logic [ROWS-1:0]   wl_q, wl_d;
    logic              wr_en_q, wr_en_d;
    logic              sense_en_q, sense_en_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic [31:0]       addrWide;
    logic              addrInRange;

    assign addrWide    = 32'(bus.addr);
    assign addrInRange = (addrWide < ROWS_U);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        we_d    = we_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (bus.en && bus.req) begin
                    row_d = bus.addr;
                    we_d  = bus.we;
                    if (addrInRange) begin
                        state_d = PRE;
                        cnt_d   = PRE_LOAD;
                        err_d   = 1'b0;
                    end else begin
                        state_d = DONE;
                        cnt_d   = '0;
                        err_d   = 1'b1;
                    end
                end
            end
            PRE: begin
                if (cnt_q == '0) begin
                    state_d = ACT;
                    cnt_d   = WL_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ACT: begin
                if (cnt_q == '0) begin
                    state_d = we_q ? DONE : SENSE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            SENSE: begin
                state_d = DONE;
                cnt_d   = '0;
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
                err_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                err_d   = 1'b0;
            end
        endcase

        // Dropping enable abandons the access outright: no done, no error, nothing resumed.
        if (!bus.en && (state_q != IDLE)) begin
            state_d = IDLE;
            cnt_d   = '0;
            err_d   = 1'b0;
        end
    end

    always_comb begin
        ready_d     = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        precharge_d = (state_d == PRE);
        wl_d        = ((state_d == ACT) || (state_d == SENSE)) ? (WL_ONE << row_d) : '0;
        wr_en_d     = (state_d == ACT) && we_d;
        sense_en_d  = (state_d == SENSE);
        done_d      = (state_d == DONE);
        error_d     = (state_d == DONE) && err_d;
    end

    // Outputs are registered from the next-state decode so they line up with the state flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            row_q       <= '0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            precharge_q <= 1'b0;
            wl_q        <= '0;
            wr_en_q     <= 1'b0;
            sense_en_q  <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            we_q        <= we_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            precharge_q <= precharge_d;
            wl_q        <= wl_d;
            wr_en_q     <= wr_en_d;
            sense_en_q  <= sense_en_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign bus.ready     = ready_q;
    assign bus.busy      = busy_q;
    assign bus.precharge = precharge_q;
    assign bus.wl        = wl_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.sense_en  = sense_en_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
endmodule

// File: tb/tb_wl_seq_decoder.sv
// Directed bench: an 8-row decoder for the main sequences and a 6-row one for the
// out-of-range address cases, both at PRE_CYCLES=1, WL_CYCLES=2.
module tb_wl_seq_decoder;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    wl_seq_decoder_if #(.ROWS(8)) busA ();
    wl_seq_decoder_if #(.ROWS(6)) busB ();

    wl_seq_decoder #(.ROWS(8), .PRE_CYCLES(1), .WL_CYCLES(2)) dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA)
    );

    wl_seq_decoder #(.ROWS(6), .PRE_CYCLES(1), .WL_CYCLES(2)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (busB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic reqV, input logic weV, input logic [2:0] addrV);
        busA.req  = reqV;
        busA.we   = weV;
        busA.addr = addrV;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Array-pin invariants hold in every cycle on both instances.
    always @(negedge clk) begin
        checkOutput("A wl one-hot", 32'($onehot0(busA.wl)), 32'd1);
        checkOutput("A precharge overlap",
                    32'(busA.precharge && ((|busA.wl) || busA.wr_en || busA.sense_en)), 32'd0);
        checkOutput("B wl one-hot", 32'($onehot0(busB.wl)), 32'd1);
        checkOutput("B precharge overlap",
                    32'(busB.precharge && ((|busB.wl) || busB.wr_en || busB.sense_en)), 32'd0);
    end

    initial begin
        logic [22:0] doneExp;
        logic [22:0] wlExp;
        logic [22:0] preExp;
        logic [22:0] wrExp;
        logic [22:0] senseExp;

        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        busA.en     = 1'b1;
        busB.en     = 1'b1;
        busB.req    = 1'b0;
        busB.we     = 1'b0;
        busB.addr   = '0;
        applyStimulus(1'b1, 1'b0, 3'd2);

        // Reset wins over a pending request.
        step();
        checkOutput("rst ready", 32'(busA.ready), 32'd1);
        checkOutput("rst busy", 32'(busA.busy), 32'd0);
        checkOutput("rst precharge", 32'(busA.precharge), 32'd0);
        checkOutput("rst wl", 32'(busA.wl), 32'd0);
        checkOutput("rst wr_en", 32'(busA.wr_en), 32'd0);
        checkOutput("rst sense_en", 32'(busA.sense_en), 32'd0);
        checkOutput("rst done", 32'(busA.done), 32'd0);
        checkOutput("rst error", 32'(busA.error), 32'd0);
        applyStimulus(1'b0, 1'b0, 3'd0);
        rst = 1'b0;
        step();

        // Read of row 5.
        applyStimulus(1'b1, 1'b0, 3'd5);
        step();
        applyStimulus(1'b0, 1'b0, 3'd0);
        checkOutput("rd c1 precharge", 32'(busA.precharge), 32'd1);
        checkOutput("rd c1 busy", 32'(busA.busy), 32'd1);
        checkOutput("rd c1 ready", 32'(busA.ready), 32'd0);
        step();
        checkOutput("rd c2 wl", 32'(busA.wl), 32'h20);
        checkOutput("rd c2 sense", 32'(busA.sense_en), 32'd0);
        step();
        checkOutput("rd c3 wl", 32'(busA.wl), 32'h20);
        checkOutput("rd c3 wr_en", 32'(busA.wr_en), 32'd0);
        step();
        checkOutput("rd c4 wl", 32'(busA.wl), 32'h20);
        checkOutput("rd c4 sense", 32'(busA.sense_en), 32'd1);
        step();
        checkOutput("rd c5 done", 32'(busA.done), 32'd1);
        checkOutput("rd c5 error", 32'(busA.error), 32'd0);
        checkOutput("rd c5 wl", 32'(busA.wl), 32'd0);
        step();
        checkOutput("rd c6 ready", 32'(busA.ready), 32'd1);
        checkOutput("rd c6 done", 32'(busA.done), 32'd0);

        // Write of row 0.
        applyStimulus(1'b1, 1'b1, 3'd0);
        step();
        applyStimulus(1'b0, 1'b0, 3'd0);
        checkOutput("wr c1 precharge", 32'(busA.precharge), 32'd1);
        step();
        checkOutput("wr c2 wl", 32'(busA.wl), 32'h01);
        checkOutput("wr c2 wr_en", 32'(busA.wr_en), 32'd1);
        step();
        checkOutput("wr c3 wl", 32'(busA.wl), 32'h01);
        checkOutput("wr c3 wr_en", 32'(busA.wr_en), 32'd1);
        checkOutput("wr c3 sense", 32'(busA.sense_en), 32'd0);
        step();
        checkOutput("wr c4 done", 32'(busA.done), 32'd1);
        checkOutput("wr c4 sense", 32'(busA.sense_en), 32'd0);
        checkOutput("wr c4 wr_en", 32'(busA.wr_en), 32'd0);
        step();

        // Read of row 3 aborted by dropping enable in cycle 2.
        applyStimulus(1'b1, 1'b0, 3'd3);
        step();
        applyStimulus(1'b0, 1'b0, 3'd0);
        step();
        checkOutput("abort c2 wl", 32'(busA.wl), 32'h08);
        busA.en = 1'b0;
        step();
        checkOutput("abort c3 wl", 32'(busA.wl), 32'd0);
        checkOutput("abort c3 precharge", 32'(busA.precharge), 32'd0);
        checkOutput("abort c3 sense", 32'(busA.sense_en), 32'd0);
        checkOutput("abort c3 busy", 32'(busA.busy), 32'd0);
        checkOutput("abort c3 ready", 32'(busA.ready), 32'd1);
        checkOutput("abort c3 done", 32'(busA.done), 32'd0);
        step();
        checkOutput("abort c4 done", 32'(busA.done), 32'd0);
        checkOutput("abort c4 busy", 32'(busA.busy), 32'd0);

        // With enable low, a request in IDLE is ignored.
        applyStimulus(1'b1, 1'b0, 3'd4);
        step();
        applyStimulus(1'b0, 1'b0, 3'd0);
        checkOutput("en0 busy", 32'(busA.busy), 32'd0);
        checkOutput("en0 ready", 32'(busA.ready), 32'd1);
        step();
        checkOutput("en0 precharge", 32'(busA.precharge), 32'd0);
        checkOutput("en0 busy later", 32'(busA.busy), 32'd0);
        busA.en = 1'b1;

        // Reset in the wordline cycle, then a normal write.
        applyStimulus(1'b1, 1'b0, 3'd3);
        step();
        applyStimulus(1'b0, 1'b0, 3'd0);
        step();
        checkOutput("mrst c2 wl", 32'(busA.wl), 32'h08);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("mrst wl", 32'(busA.wl), 32'd0);
        checkOutput("mrst ready", 32'(busA.ready), 32'd1);
        checkOutput("mrst done", 32'(busA.done), 32'd0);
        checkOutput("mrst busy", 32'(busA.busy), 32'd0);
        step();
        checkOutput("mrst later done", 32'(busA.done), 32'd0);
        applyStimulus(1'b1, 1'b1, 3'd6);
        step();
        applyStimulus(1'b0, 1'b0, 3'd0);
        checkOutput("post-rst c1 precharge", 32'(busA.precharge), 32'd1);
        step();
        checkOutput("post-rst c2 wl", 32'(busA.wl), 32'h40);
        checkOutput("post-rst c2 wr_en", 32'(busA.wr_en), 32'd1);
        step();
        step();
        checkOutput("post-rst c4 done", 32'(busA.done), 32'd1);
        checkOutput("post-rst c4 error", 32'(busA.error), 32'd0);
        step();
        checkOutput("post-rst c5 ready", 32'(busA.ready), 32'd1);

        // req held high, we alternating read/write/read/write on row 1.
        doneExp  = '0;
        wlExp    = '0;
        preExp   = '0;
        wrExp    = '0;
        senseExp = '0;
        doneExp[5]   = 1'b1; doneExp[10]  = 1'b1; doneExp[16] = 1'b1; doneExp[21] = 1'b1;
        preExp[1]    = 1'b1; preExp[7]    = 1'b1; preExp[12]  = 1'b1; preExp[18]  = 1'b1;
        wlExp[2]     = 1'b1; wlExp[3]     = 1'b1; wlExp[4]    = 1'b1;
        wlExp[8]     = 1'b1; wlExp[9]     = 1'b1;
        wlExp[13]    = 1'b1; wlExp[14]    = 1'b1; wlExp[15]   = 1'b1;
        wlExp[19]    = 1'b1; wlExp[20]    = 1'b1;
        wrExp[8]     = 1'b1; wrExp[9]     = 1'b1; wrExp[19]   = 1'b1; wrExp[20]   = 1'b1;
        senseExp[4]  = 1'b1; senseExp[15] = 1'b1;
        applyStimulus(1'b1, 1'b0, 3'd1);
        for (int c = 1; c <= 22; c++) begin
            step();
            checkOutput($sformatf("b2b c%0d done", c), 32'(busA.done), 32'(doneExp[c]));
            checkOutput($sformatf("b2b c%0d precharge", c), 32'(busA.precharge), 32'(preExp[c]));
            checkOutput($sformatf("b2b c%0d wl", c), 32'(busA.wl), wlExp[c] ? 32'h02 : 32'h00);
            checkOutput($sformatf("b2b c%0d wr_en", c), 32'(busA.wr_en), 32'(wrExp[c]));
            checkOutput($sformatf("b2b c%0d sense", c), 32'(busA.sense_en), 32'(senseExp[c]));
            if (c == 6 || c == 17) busA.we = 1'b1;
            if (c == 11) busA.we = 1'b0;
            if (c == 22) applyStimulus(1'b0, 1'b0, 3'd0);
        end
        step();

        // Six-row decoder: addresses 7 and 6 are out of range, 5 is the top row.
        busB.req  = 1'b1;
        busB.we   = 1'b0;
        busB.addr = 3'd7;
        step();
        busB.req = 1'b0;
        checkOutput("oor7 done", 32'(busB.done), 32'd1);
        checkOutput("oor7 error", 32'(busB.error), 32'd1);
        checkOutput("oor7 wl", 32'(busB.wl), 32'd0);
        checkOutput("oor7 precharge", 32'(busB.precharge), 32'd0);
        step();
        checkOutput("oor7 c2 ready", 32'(busB.ready), 32'd1);
        checkOutput("oor7 c2 error", 32'(busB.error), 32'd0);
        busB.req  = 1'b1;
        busB.we   = 1'b1;
        busB.addr = 3'd6;
        step();
        busB.req = 1'b0;
        checkOutput("oor6 error", 32'(busB.error), 32'd1);
        checkOutput("oor6 wr_en", 32'(busB.wr_en), 32'd0);
        step();
        busB.req  = 1'b1;
        busB.we   = 1'b0;
        busB.addr = 3'd5;
        step();
        busB.req = 1'b0;
        checkOutput("row5 c1 precharge", 32'(busB.precharge), 32'd1);
        step();
        checkOutput("row5 c2 wl", 32'(busB.wl), 32'h20);
        step();
        step();
        checkOutput("row5 c4 sense", 32'(busB.sense_en), 32'd1);
        step();
        checkOutput("row5 c5 done", 32'(busB.done), 32'd1);
        checkOutput("row5 c5 error", 32'(busB.error), 32'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/wl_seq_decoder.md
# wl_seq_decoder

Parametrised, sequenced row decoder for the RAM array. It accepts a one-cycle row-access request and drives the array control pins in a fixed order: precharge, then a one-hot registered wordline, then either a sense pulse (read) or a write enable (write). It sits between the RAM access controller and the analog bitcell/sense-amp macro. It replaces the bare combinational 3-to-8 decoder with glitch-free, timed wordline control.

## Interface
Parameters:
- ROWS, 8: number of wordlines, ≥2; need not be a power of two.
- ADDR_W, $clog2(ROWS): row address width.
- PRE_CYCLES, 1: precharge duration in cycles, ≥1.
- WL_CYCLES, 2: wordline-active duration before sense/complete, ≥1.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  block enable; low blocks acceptance and aborts any access in flight.
- req  in  1  access request; sampled only when ready=1.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  ADDR_W  row address; sampled with req.
- ready  out  1  high in IDLE; request accepted on the edge where req & ready & en.
- busy  out  1  high in every non-IDLE state.
- precharge  out  1  bitline precharge.
- wl  out  ROWS  one-hot wordline select, all-zero when inactive.
- wr_en  out  1  write-driver enable.
- sense_en  out  1  sense-amp strobe.
- done  out  1  one-cycle completion pulse.
- error  out  1  one-cycle pulse, coincident with done, for an out-of-range address.

## Operation
- FSM states: IDLE, PRE, ACT, SENSE, DONE.
- All outputs are Moore outputs. They are decoded from registered state, the registered address and the registered we. There is no combinational path from input to output.
- On acceptance: latch addr → row_q and we → we_q.
  - If addr < ROWS: go to PRE.
  - Otherwise: go directly to DONE with err_q=1, and raise no precharge, wl, wr_en or sense_en.
- PRE: precharge=1 for PRE_CYCLES cycles (down-counter), then go to ACT.
- ACT: wl[row_q]=1 for WL_CYCLES cycles. wr_en=we_q throughout ACT. Exit to SENSE if we_q=0, else to DONE.
- SENSE (reads only): one cycle with wl[row_q]=1 and sense_en=1. Then go to DONE.
- DONE: one cycle with done=1 and error=err_q, all array pins low. Then go to IDLE and clear err_q.
- wl is never non-zero outside ACT/SENSE, and never has more than one bit set.
- precharge is never high in the same cycle as wl, wr_en or sense_en.
- en=0 in any non-IDLE state: at the next edge go to IDLE with all array pins low. No done or error is generated. An aborted access is dropped, not resumed.
- en=0 in IDLE: ready stays 1, but req is ignored.
- req while busy is ignored and not queued.
- The counter is sized $clog2(max(PRE_CYCLES, WL_CYCLES)+1) and reloads on every state entry.

## Timing
- Reset: the edge with rst=1 forces IDLE, cleared counters, and row_q=0, we_q=0, err_q=0. rst wins over en and req.
- Output values in the cycle after the reset edge: ready=1, busy=0, precharge=0, wl=0, wr_en=0, sense_en=0, done=0, error=0.
- Reset mid-access behaves like an abort: no done.
- Cycle numbering: the acceptance edge ends cycle 0; cycles are counted after it.
  - Precharge: cycles 1..P, where P=PRE_CYCLES.
  - Wordline: cycles P+1..P+W, where W=WL_CYCLES.
  - Read: SENSE is cycle P+W+1 and done is cycle P+W+2.
  - Write: done is cycle P+W+1.
  - Out-of-range address: done=error=1 in cycle 1.
- ready returns to 1 in the cycle after done. A request held high is accepted at the end of that cycle, with no dead cycle beyond DONE.
- Throughput, one access per: read P+W+3 cycles, write P+W+2 cycles.

## Test plan
- ROWS=8, P=1, W=2; read of addr=5: precharge=1 in cycle 1; wl=8'b0010_0000 in cycles 2–3; wl held and sense_en=1 in cycle 4; done=1, error=0 in cycle 5; ready=1 in cycle 6.
- Write of addr=0: precharge in cycle 1; wl=8'h01 and wr_en=1 in cycles 2–3; sense_en never asserted; done in cycle 4.
- ROWS=6 (ADDR_W=3); request addr=7: done=error=1 in cycle 1, wl=0 and precharge=0 throughout. A following request to addr=5 drives wl=6'b100000.
- Read of addr=3 with en dropped during cycle 2: all pins low from cycle 3; state IDLE; done never asserted. With en=0 in IDLE, a req pulse is ignored: busy stays 0.
- rst asserted in the cycle where wl=8'h08: from the next cycle wl=0, ready=1, done=0. A new request after reset completes normally.
- req held high continuously with alternating we: back-to-back accesses with done spaced 6/5 cycles apart (P=1, W=2); wl is one-hot every cycle (checked by assertion); precharge and wl never overlap.
